id_exe_pipe_reg: RTL and testbench

- Pipeline register between the ID stage (instruction controller, register file read, immediate/operand muxing) and the EXE stage (ALU, branch condition check).
- Captures the decoded control bundle plus operand values every cycle.
- Inserts bubbles on load-use hazards, squashes on taken branches, and holds state on pipeline freeze.
- Adds a valid bit so downstream stages and hazard logic can tell real instructions from bubbles.

---
 rtl/id_exe_pipe_reg_pkg.sv | 32 +++
 rtl/id_exe_pipe_reg_en_clr.sv | 22 ++
 rtl/id_exe_pipe_reg.sv | 109 ++++++++++
 tb/tb_id_exe_pipe_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/id_exe_pipe_reg_pkg.sv
// Shared ID/EXE definitions: word/address widths, ALU command and branch condition encodings.
// Macros stay visible to any file compiled after this one; the package mirrors them as typed constants.
`ifndef ID_EXE_DEFINES_SV
`define ID_EXE_DEFINES_SV
`define WORD_LEN           32
`define REG_FILE_ADDR_LEN  5
`define EXE_CMD_LEN        4
`define EXE_ADD            4'b0000
`define EXE_SUB            4'b0010
`define EXE_AND            4'b0100
`define EXE_OR             4'b0101
`define EXE_NO_OPERATION   4'b1111
`define COND_NOTHING       2'b00
`define COND_BNE           2'b01
`define COND_JUMP          2'b10
`define COND_BEZ           2'b11
`endif

package id_exe_pipe_reg_pkg;
  localparam int DEF_WORD_LEN     = `WORD_LEN;
  localparam int DEF_REG_ADDR_LEN = `REG_FILE_ADDR_LEN;
  localparam int DEF_EXE_CMD_W    = `EXE_CMD_LEN;

  localparam logic [`EXE_CMD_LEN-1:0] EXE_NOP     = `EXE_NO_OPERATION;
  localparam logic [`EXE_CMD_LEN-1:0] EXE_ADD_CMD = `EXE_ADD;
  localparam logic [`EXE_CMD_LEN-1:0] EXE_SUB_CMD = `EXE_SUB;

  localparam logic [1:0] BR_NOTHING = `COND_NOTHING;
  localparam logic [1:0] BR_BNE     = `COND_BNE;
  localparam logic [1:0] BR_JUMP    = `COND_JUMP;
  localparam logic [1:0] BR_BEZ     = `COND_BEZ;
endpackage

// File: rtl/id_exe_pipe_reg_en_clr.sv
// Generic register: sync rst and clr both load CLR_VAL, en gates every non-reset update.
// One cycle latency; en=0 holds the value, and rst overrides en.
module register_en_clr #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= CLR_VAL;
    else if (en)
      q <= clr ? CLR_VAL : d;
  end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register, 1-cycle latency; freeze holds everything, flush/hazard load a bubble.
// Optional ID_EXE_PERF_CNT_EN adds wrapping 32-bit bubble/flush/freeze event counters.
module id_exe_pipe_reg
  import id_exe_pipe_reg_pkg::*;
#(
  parameter int WORD_LEN     = DEF_WORD_LEN,
  parameter int REG_ADDR_LEN = DEF_REG_ADDR_LEN,
  parameter int EXE_CMD_W    = DEF_EXE_CMD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    hazard_detected,
  input  logic [WORD_LEN-1:0]     pc_in,
  input  logic [EXE_CMD_W-1:0]    exe_cmd_in,
  input  logic                    branch_en_in,
  input  logic                    wb_en_in,
  input  logic                    mem_r_en_in,
  input  logic                    mem_w_en_in,
  input  logic [1:0]              branch_cmd_in,
  input  logic [WORD_LEN-1:0]     val1_in,
  input  logic [WORD_LEN-1:0]     val2_in,
  input  logic [WORD_LEN-1:0]     st_val_in,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  input  logic [REG_ADDR_LEN-1:0] src1_in,
  input  logic [REG_ADDR_LEN-1:0] src2_in,
  output logic [WORD_LEN-1:0]     pc_out,
  output logic [EXE_CMD_W-1:0]    exe_cmd_out,
  output logic                    branch_en_out,
  output logic                    wb_en_out,
  output logic                    mem_r_en_out,
  output logic                    mem_w_en_out,
  output logic [1:0]              branch_cmd_out,
  output logic [WORD_LEN-1:0]     val1_out,
  output logic [WORD_LEN-1:0]     val2_out,
  output logic [WORD_LEN-1:0]     st_val_out,
  output logic [REG_ADDR_LEN-1:0] dest_out,
  output logic [REG_ADDR_LEN-1:0] src1_out,
  output logic [REG_ADDR_LEN-1:0] src2_out,
`ifdef ID_EXE_PERF_CNT_EN
  output logic [31:0]             bubble_cnt_out,
  output logic [31:0]             flush_cnt_out,
  output logic [31:0]             freeze_cnt_out,
`endif
  output logic                    valid_out
);

  logic en;
  logic clr;

  // Bubble is forced here so a misbehaving controller can never leak a write downstream.
  assign en  = ~freeze;
  assign clr = flush | hazard_detected;

  register_en_clr #(.WIDTH(WORD_LEN)) u_pc (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(pc_in), .q(pc_out));
  register_en_clr #(.WIDTH(EXE_CMD_W), .CLR_VAL(EXE_CMD_W'(EXE_NOP))) u_exe_cmd (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(exe_cmd_in), .q(exe_cmd_out));
  register_en_clr #(.WIDTH(1)) u_branch_en (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(branch_en_in), .q(branch_en_out));
  register_en_clr #(.WIDTH(1)) u_wb_en (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(wb_en_in), .q(wb_en_out));
  register_en_clr #(.WIDTH(1)) u_mem_r_en (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(mem_r_en_in), .q(mem_r_en_out));
  register_en_clr #(.WIDTH(1)) u_mem_w_en (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(mem_w_en_in), .q(mem_w_en_out));
  register_en_clr #(.WIDTH(2)) u_branch_cmd (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(branch_cmd_in), .q(branch_cmd_out));
  register_en_clr #(.WIDTH(WORD_LEN)) u_val1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(val1_in), .q(val1_out));
  register_en_clr #(.WIDTH(WORD_LEN)) u_val2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(val2_in), .q(val2_out));
  register_en_clr #(.WIDTH(WORD_LEN)) u_st_val (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(st_val_in), .q(st_val_out));
  // Zeroed addresses point at r0, which the forwarding unit never matches.
  register_en_clr #(.WIDTH(REG_ADDR_LEN)) u_dest (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(dest_in), .q(dest_out));
  register_en_clr #(.WIDTH(REG_ADDR_LEN)) u_src1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(src1_in), .q(src1_out));
  register_en_clr #(.WIDTH(REG_ADDR_LEN)) u_src2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(src2_in), .q(src2_out));
  register_en_clr #(.WIDTH(1)) u_valid (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(1'b1), .q(valid_out));

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] freeze_cnt_q;

  // Hazard bubbles are only counted when flush does not already own the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (!freeze && !flush && hazard_detected) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (!freeze && flush)                     flush_cnt_q  <= flush_cnt_q + 32'd1;
      if (freeze)                               freeze_cnt_q <= freeze_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt_out = bubble_cnt_q;
  assign flush_cnt_out  = flush_cnt_q;
  assign freeze_cnt_out = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed bench for id_exe_pipe_reg: reset, load, hazard bubble, freeze hold, flush, reset mid-stream.
module tb_id_exe_pipe_reg;
  import id_exe_pipe_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, hazard_detected;
  logic [31:0] pc_in, val1_in, val2_in, st_val_in;
  logic [3:0]  exe_cmd_in;
  logic        branch_en_in, wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [1:0]  branch_cmd_in;
  logic [4:0]  dest_in, src1_in, src2_in;
  logic [31:0] pc_out, val1_out, val2_out, st_val_out;
  logic [3:0]  exe_cmd_out;
  logic        branch_en_out, wb_en_out, mem_r_en_out, mem_w_en_out, valid_out;
  logic [1:0]  branch_cmd_out;
  logic [4:0]  dest_out, src1_out, src2_out;
`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] bubble_cnt_out, flush_cnt_out, freeze_cnt_out;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_exe_pipe_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard_detected(hazard_detected),
    .pc_in(pc_in), .exe_cmd_in(exe_cmd_in), .branch_en_in(branch_en_in), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .branch_cmd_in(branch_cmd_in),
    .val1_in(val1_in), .val2_in(val2_in), .st_val_in(st_val_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .pc_out(pc_out), .exe_cmd_out(exe_cmd_out), .branch_en_out(branch_en_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .branch_cmd_out(branch_cmd_out), .val1_out(val1_out), .val2_out(val2_out),
    .st_val_out(st_val_out), .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
`ifdef ID_EXE_PERF_CNT_EN
    .bubble_cnt_out(bubble_cnt_out), .flush_cnt_out(flush_cnt_out),
    .freeze_cnt_out(freeze_cnt_out),
`endif
    .valid_out(valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [31:0] pc, input logic [3:0] cmd, input logic br_en,
                            input logic wb, input logic mr, input logic mw, input logic [1:0] bc,
                            input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] sv,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    pc_in = pc; exe_cmd_in = cmd; branch_en_in = br_en; wb_en_in = wb;
    mem_r_en_in = mr; mem_w_en_in = mw; branch_cmd_in = bc;
    val1_in = v1; val2_in = v2; st_val_in = sv; dest_in = d; src1_in = s1; src2_in = s2;
  endtask

  task automatic set_random();
    set_bundle($urandom, 4'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 2'($urandom),
               $urandom, $urandom, $urandom, 5'($urandom_range(1, 31)),
               5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"},   32'(valid_out),     32'd0);
    chk({tag, "_exe_cmd"}, 32'(exe_cmd_out),   32'(EXE_NOP));
    chk({tag, "_wb"},      32'(wb_en_out),     32'd0);
    chk({tag, "_mem_r"},   32'(mem_r_en_out),  32'd0);
    chk({tag, "_mem_w"},   32'(mem_w_en_out),  32'd0);
    chk({tag, "_br_en"},   32'(branch_en_out), 32'd0);
    chk({tag, "_br_cmd"},  32'(branch_cmd_out), 32'd0);
    chk({tag, "_dest"},    32'(dest_out),      32'd0);
    chk({tag, "_src1"},    32'(src1_out),      32'd0);
    chk({tag, "_src2"},    32'(src2_out),      32'd0);
    chk({tag, "_pc"},      pc_out,             32'd0);
    chk({tag, "_val1"},    val1_out,           32'd0);
    chk({tag, "_val2"},    val2_out,           32'd0);
    chk({tag, "_st_val"},  st_val_out,         32'd0);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard_detected = 1'b0;
    set_random();
    #2;
    tick();
    chk_bubble("rst1");
    set_random();
    tick();
    chk_bubble("rst2");
`ifdef ID_EXE_PERF_CNT_EN
    chk("rst_bubble_cnt", bubble_cnt_out, 32'd0);
    chk("rst_flush_cnt",  flush_cnt_out,  32'd0);
    chk("rst_freeze_cnt", freeze_cnt_out, 32'd0);
`endif

    // ADD r3 = 5 + 7
    rst = 1'b0;
    set_bundle(32'h4, EXE_ADD_CMD, 0, 1, 0, 0, BR_NOTHING, 32'h5, 32'h7, 32'h0, 5'd3, 5'd1, 5'd2);
    tick();
    chk("add_valid",   32'(valid_out),   32'd1);
    chk("add_exe_cmd", 32'(exe_cmd_out), 32'(EXE_ADD_CMD));
    chk("add_wb",      32'(wb_en_out),   32'd1);
    chk("add_val1",    val1_out,         32'h5);
    chk("add_val2",    val2_out,         32'h7);
    chk("add_dest",    32'(dest_out),    32'd3);
    chk("add_src1",    32'(src1_out),    32'd1);
    chk("add_src2",    32'(src2_out),    32'd2);
    chk("add_pc",      pc_out,           32'h4);

    // ST under a load-use hazard becomes a bubble, then loads once the hazard drops
    hazard_detected = 1'b1;
    set_bundle(32'h8, EXE_ADD_CMD, 0, 0, 0, 1, BR_NOTHING, 32'h40, 32'h8, 32'h55, 5'd5, 5'd6, 5'd9);
    tick();
    chk_bubble("haz");
    hazard_detected = 1'b0;
    tick();
    chk("st_valid",  32'(valid_out),    32'd1);
    chk("st_mem_w",  32'(mem_w_en_out), 32'd1);
    chk("st_st_val", st_val_out,        32'h55);
    chk("st_dest",   32'(dest_out),     32'd5);
    chk("st_val1",   val1_out,          32'h40);

    // LD held through a 3-cycle freeze while inputs churn and flush is high
    set_bundle(32'h20, EXE_ADD_CMD, 0, 1, 1, 0, BR_NOTHING, 32'h100, 32'h10, 32'h0, 5'd7, 5'd4, 5'd0);
    tick();
    chk("ld_mem_r", 32'(mem_r_en_out), 32'd1);
    freeze = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_random();
      hazard_detected = 1'(i);
      tick();
      chk("frz_valid", 32'(valid_out),    32'd1);
      chk("frz_mem_r", 32'(mem_r_en_out), 32'd1);
      chk("frz_wb",    32'(wb_en_out),    32'd1);
      chk("frz_dest",  32'(dest_out),     32'd7);
      chk("frz_val1",  val1_out,          32'h100);
      chk("frz_val2",  val2_out,          32'h10);
      chk("frz_pc",    pc_out,            32'h20);
    end
`ifdef ID_EXE_PERF_CNT_EN
    chk("frz_cnt3", freeze_cnt_out, 32'd3);
`endif
    freeze = 1'b0; hazard_detected = 1'b0;
    set_random();
    tick();
    chk_bubble("unfrz_flush");

    // Flush and hazard together: one bubble, counted as a flush only
    flush = 1'b1; hazard_detected = 1'b1;
    set_random();
    tick();
    chk_bubble("flush_haz");
`ifdef ID_EXE_PERF_CNT_EN
    chk("fh_flush_cnt",  flush_cnt_out,  32'd2);
    chk("fh_bubble_cnt", bubble_cnt_out, 32'd1);
`endif

    // Controls drop: the very next bundle loads, no lingering bubble
    flush = 1'b0; hazard_detected = 1'b0;
    set_bundle(32'h30, EXE_SUB_CMD, 1, 0, 0, 0, BR_BNE, 32'h9, 32'h9, 32'h12, 5'd0, 5'd8, 5'd10);
    tick();
    chk("bne_valid",  32'(valid_out),      32'd1);
    chk("bne_br_en",  32'(branch_en_out),  32'd1);
    chk("bne_br_cmd", 32'(branch_cmd_out), 32'(BR_BNE));
    chk("bne_cmd",    32'(exe_cmd_out),    32'(EXE_SUB_CMD));
    chk("bne_st_val", st_val_out,          32'h12);

    // Reset beats freeze, then the first non-reset edge loads normally
    rst = 1'b1; freeze = 1'b1;
    set_random();
    tick();
    chk_bubble("rst_frz");
    rst = 1'b0; freeze = 1'b0;
    set_bundle(32'h44, EXE_ADD_CMD, 0, 1, 0, 0, BR_JUMP, 32'hA, 32'hB, 32'hC, 5'd12, 5'd13, 5'd14);
    tick();
    chk("post_rst_valid", 32'(valid_out), 32'd1);
    chk("post_rst_dest",  32'(dest_out),  32'd12);
    chk("post_rst_br",    32'(branch_cmd_out), 32'(BR_JUMP));

`ifdef ID_EXE_PERF_CNT_EN
    chk("prst_freeze_cnt", freeze_cnt_out, 32'd0);
    force dut.freeze_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.freeze_cnt_q;
    freeze = 1'b1;
    tick();
    chk("freeze_wrap", freeze_cnt_out, 32'd0);
    freeze = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
